// File: rtl/cr_kme_fifo_arb.sv
// Packet-locked round-robin arbiter feeding the KME staging FIFO write port; latency 1 cycle (ack -> fifo_in_valid).
// Backpressure: fifo_in_stall holds the registered stage and suppresses req_ack until the stage can drain.
module cr_kme_fifo_arb #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 71,
   parameter int EOT_BIT = 70
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           req_ack,
   output logic [DATA_W-1:0]          fifo_in,
   output logic                       fifo_in_valid,
   input  logic                       fifo_in_stall,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy
);

   localparam int ID_W = $clog2(N_REQ);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PKT  = 1'b1;

   logic [0:0]        state;
   logic [ID_W-1:0]   rr_ptr;
   logic              out_vld;
   logic [DATA_W-1:0] out_data;

   logic              drain;
   logic              load_ok;
   logic              pick_found;
   logic [ID_W-1:0]   pick_id;
   logic [ID_W:0]     cand;
   logic              sel_vld;
   logic [ID_W-1:0]   sel_id;
   logic [ID_W-1:0]   sel_next;
   logic [DATA_W-1:0] sel_data;
   logic              accept;
   logic              sel_eot;

   assign fifo_in       = out_data;
   assign fifo_in_valid = out_vld & ~fifo_in_stall;
   assign drain         = fifo_in_valid;
   assign load_ok       = ~out_vld | drain;
   assign busy          = (state == ST_PKT);

   // Descending scan so the candidate closest to rr_ptr wins.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (cand >= (ID_W + 1)'(N_REQ)) begin
            cand = cand - (ID_W + 1)'(N_REQ);
         end
         if (req_valid[cand[ID_W-1:0]]) begin
            pick_found = 1'b1;
            pick_id    = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      if (state == ST_PKT) begin
         sel_id  = grant_id;
         sel_vld = req_valid[grant_id];
      end else begin
         sel_id  = pick_id;
         sel_vld = pick_found;
      end
   end

   assign sel_data = req_data[int'(sel_id) * DATA_W +: DATA_W];
   assign sel_eot  = sel_data[EOT_BIT];
   assign sel_next = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
   // Gating with rst keeps req_ack at its reset value while reset is held.
   assign accept   = sel_vld & load_ok & ~rst;

   always_comb begin
      req_ack = '0;
      if (accept) begin
         req_ack[sel_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         out_vld  <= 1'b0;
         out_data <= '0;
         grant_id <= '0;
      end else begin
         if (accept) begin
            out_data <= sel_data;
            out_vld  <= 1'b1;
            grant_id <= sel_id;
            if (sel_eot) begin
               state  <= ST_IDLE;
               rr_ptr <= sel_next;
            end else begin
               state  <= ST_PKT;
            end
         end else if (drain) begin
            out_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// Directed bench for cr_kme_fifo_arb: acked beats go into a scoreboard queue and are matched against FIFO writes.
module tb_cr_kme_fifo_arb;

   logic          clk;
   logic          rst;
   logic [3:0]    req_valid;
   logic [70:0]   d [4];
   logic [283:0]  req_data;
   logic [3:0]    req_ack;
   logic [70:0]   fifo_in;
   logic          fifo_in_valid;
   logic          fifo_in_stall;
   logic [1:0]    grant_id;
   logic          busy;

   logic [70:0]   exp_q [$];
   logic [70:0]   exp_front;
   logic [1:0]    exp_gid;
   int            n_tests;
   int            n_fail;

   assign req_data = {d[3], d[2], d[1], d[0]};

   cr_kme_fifo_arb #(.N_REQ(4), .DATA_W(71), .EOT_BIT(70)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .fifo_in       (fifo_in),
      .fifo_in_valid (fifo_in_valid),
      .fifo_in_stall (fifo_in_stall),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [70:0] beat(input int r, input int s, input logic eot);
      return {eot, 54'h0, 8'(r), 8'(s)};
   endfunction

   task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: inputs were driven at posedge+1, outputs are sampled at the negedge.
   task automatic step(input logic [3:0] ea, input logic eb, input logic efv);
      @(negedge clk);
      check("req_ack", 71'(req_ack), 71'(ea));
      check("busy", 71'(busy), 71'(eb));
      check("grant_id", 71'(grant_id), 71'(exp_gid));
      check("fifo_in_valid", 71'(fifo_in_valid), 71'(efv));
      if (fifo_in_stall) begin
         check("valid_under_stall", 71'(fifo_in_valid), 71'(0));
         if (exp_q.size() > 0) check("stall_hold_data", fifo_in, exp_q[0]);
      end
      if (fifo_in_valid) begin
         n_tests++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed %0h expected no write", fifo_in);
         end
         if (exp_q.size() > 0) begin
            exp_front = exp_q.pop_front();
            check("fifo_in_data", fifo_in, exp_front);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (ea[i]) begin
            exp_q.push_back(d[i]);
            exp_gid = 2'(i);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      exp_gid       = 2'd0;
      rst           = 1'b1;
      fifo_in_stall = 1'b0;
      req_valid     = 4'b1111;
      for (int i = 0; i < 4; i++) d[i] = beat(i, 0, 1'b1);

      // Reset state, with requesters valid to show no ack leaks out.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_fifo_in_valid", 71'(fifo_in_valid), 71'(0));
      check("rst_req_ack", 71'(req_ack), 71'(0));
      check("rst_busy", 71'(busy), 71'(0));
      check("rst_grant_id", 71'(grant_id), 71'(0));
      check("rst_fifo_in", fifo_in, 71'(0));
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 4'b0000;

      // Requester 2: 3-beat packet.
      req_valid = 4'b0100; d[2] = beat(2, 0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      d[2] = beat(2, 1, 1'b0);
      step(4'b0100, 1'b1, 1'b1);
      d[2] = beat(2, 2, 1'b1);
      step(4'b0100, 1'b1, 1'b1);
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);
      // rr_ptr now 3: requester 3 beats requester 0.
      req_valid = 4'b1001; d[0] = beat(0, 0, 1'b1); d[3] = beat(3, 0, 1'b1);
      step(4'b1000, 1'b0, 1'b0);
      req_valid = 4'b0001;
      step(4'b0001, 1'b0, 1'b1);
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);

      // Move rr_ptr to 0, then requesters 0 and 1 with 2-beat packets.
      req_valid = 4'b1000; d[3] = beat(3, 1, 1'b1);
      step(4'b1000, 1'b0, 1'b0);
      req_valid = 4'b0011; d[0] = beat(0, 1, 1'b0); d[1] = beat(1, 1, 1'b0);
      step(4'b0001, 1'b0, 1'b1);
      d[0] = beat(0, 2, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      d[0] = beat(0, 3, 1'b1);
      step(4'b0010, 1'b0, 1'b1);
      req_valid = 4'b0111; d[1] = beat(1, 2, 1'b1); d[2] = beat(2, 3, 1'b1);
      step(4'b0010, 1'b1, 1'b1);
      req_valid = 4'b0101;
      step(4'b0100, 1'b0, 1'b1);
      req_valid = 4'b0001;
      step(4'b0001, 1'b0, 1'b1);
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);

      // All four valid with single-beat packets: rotation from rr_ptr=1.
      for (int i = 0; i < 4; i++) d[i] = beat(i, 10, 1'b1);
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         step(4'(1 << ((1 + i) % 4)), 1'b0, (i > 0));
         d[(1 + i) % 4] = beat((1 + i) % 4, 11 + i, 1'b1);
      end
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);

      // Requester 1 mid-packet with a 2-cycle gap; requester 3 must wait for EOT.
      req_valid = 4'b1010; d[1] = beat(1, 20, 1'b0); d[3] = beat(3, 20, 1'b1);
      step(4'b0010, 1'b0, 1'b0);
      req_valid = 4'b1000;
      step(4'b0000, 1'b1, 1'b1);
      step(4'b0000, 1'b1, 1'b0);
      req_valid = 4'b1010; d[1] = beat(1, 21, 1'b1);
      step(4'b0010, 1'b1, 1'b0);
      req_valid = 4'b1000;
      step(4'b1000, 1'b0, 1'b1);
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);

      // Stall for 5 cycles with the stage full; release writes and acks together.
      req_valid = 4'b0001; d[0] = beat(0, 30, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      fifo_in_stall = 1'b1; d[0] = beat(0, 31, 1'b0);
      repeat (5) step(4'b0000, 1'b1, 1'b0);
      fifo_in_stall = 1'b0;
      step(4'b0001, 1'b1, 1'b1);
      d[0] = beat(0, 32, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);

      // Reset on beat 2 of a 4-beat packet from requester 1.
      req_valid = 4'b0010; d[1] = beat(1, 40, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      d[1] = beat(1, 41, 1'b0);
      step(4'b0010, 1'b1, 1'b1);
      d[1] = beat(1, 42, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_fifo_in_valid", 71'(fifo_in_valid), 71'(0));
      check("midrst_req_ack", 71'(req_ack), 71'(0));
      check("midrst_busy", 71'(busy), 71'(0));
      check("midrst_grant_id", 71'(grant_id), 71'(0));
      check("midrst_fifo_in", fifo_in, 71'(0));
      exp_q.delete();
      exp_gid = 2'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = 4'b0100; d[2] = beat(2, 50, 1'b1);
      step(4'b0100, 1'b0, 1'b0);
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);

      check("scoreboard_drained", 71'(exp_q.size()), 71'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cr_kme_fifo_arb.md
# cr_kme_fifo_arb

Packet-aware round-robin arbiter that shares one KME staging FIFO (71-bit entries, stall-on-no-free-slot write interface) among up to N_REQ producers. It sits directly upstream of the FIFO write port. It locks the grant to one requester from first beat to end-of-packet so packets never interleave. It also drives the write side through a single registered output stage.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- DATA_W, default 71: entry width, matches the FIFO.
- EOT_BIT, default 70: bit index of req_data that marks the last beat of a packet.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester beat valid.
- req_data  input  N_REQ*DATA_W  per-requester beat; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  output  N_REQ  beat accepted from requester i this cycle; one-hot or zero.
- fifo_in  output  DATA_W  write data to the FIFO.
- fifo_in_valid  output  1  write enable to the FIFO.
- fifo_in_stall  input  1  FIFO has no free slot.
- grant_id  output  clog2(N_REQ)  current or last owner.
- busy  output  1  a packet is in progress, state PKT.

## Operation
- Output stage: register out_data and out_vld.
  - fifo_in = out_data.
  - fifo_in_valid = out_vld & ~fifo_in_stall.
  - drain = fifo_in_valid.
- Stage can load when load_ok = ~out_vld | drain.
- FSM, 2 states:
  - IDLE: no owner. If load_ok and any req_valid, pick the first valid requester at or after rr_ptr, searching upward with wrap. Accept its beat: req_ack[w]=1, load the stage, set grant_id=w. If the beat has EOT=0, go to PKT. If EOT=1, stay in IDLE and set rr_ptr=w+1 mod N_REQ.
  - PKT: only requester grant_id is considered. Accept when req_valid[grant_id] & load_ok. On an accepted beat with EOT=1, return to IDLE and set rr_ptr=grant_id+1 mod N_REQ. Other requesters are ignored regardless of their valid.
- A requester must hold req_valid/req_data stable until acked. The arbiter does not check this.
- Simultaneous drain and load in the same cycle: stage takes the new beat and out_vld stays 1. Drain without load: out_vld goes to 0.
- req_ack is combinational from req_valid, state, rr_ptr, out_vld and fifo_in_stall. There is no combinational path from req_valid to fifo_in_valid.
- rr_ptr wraps from N_REQ-1 to 0.

## Timing
- Reset values: state=IDLE, rr_ptr=0, out_vld=0, out_data=0, grant_id=0. Outputs at reset: fifo_in_valid=0, req_ack=0, busy=0.
- Latency: a beat acked in cycle t appears on fifo_in with fifo_in_valid in cycle t+1, if fifo_in_stall=0.
- Throughput: 1 beat/cycle while unstalled, including back-to-back packets from different requesters. The IDLE-state pick happens in the same cycle as the previous EOT drains.
- Stall: while fifo_in_stall=1 and out_vld=1, fifo_in_valid=0, req_ack=0, and out_data holds.
- If rst asserts mid-packet, the in-flight beat is dropped and state returns to IDLE. Requesters must restart packets after reset.
- fifo_in_valid is never asserted while fifo_in_stall=1, so the FIFO overflow flag must never fire.

## Test plan
- Reset, then a single requester 2 sends a 3-beat packet with EOT on beat 3. Required: req_ack[2] in cycles 1,2,3; fifo_in_valid in cycles 2,3,4 with matching data; rr_ptr=3 afterwards.
- Requesters 0 and 1 both hold a 2-beat packet. Required order: 0,0,1,1 with no interleave. busy=1 across each packet. The next winner is 2 if valid, else 0.
- All four requesters continuously valid with 1-beat packets. Required: grants 0,1,2,3,0,… at one beat per cycle.
- Requester 1 is mid-packet while requester 3 is valid and requester 1 deasserts valid for 2 cycles. Required: no ack to 3 and no fifo_in_valid bubble beyond the gap. Requester 3 is acked only after requester 1's EOT.
- Hold fifo_in_stall=1 for 5 cycles with out_vld=1. Required: fifo_in_valid=0, req_ack=0, and fifo_in stable. On release, the held beat is written and a new beat is acked in the same cycle.
- Assert rst mid-packet on beat 2 of 4. Required: all outputs return to reset values immediately. After reset, a packet from a different requester is accepted from IDLE.
